mem_access_ctrl: RTL and testbench

Load/store sequencer between the CPU memory stage and the data-memory bus. Accepts one word, half-word or byte access at a time, drives a req/ack memory handshake with byte enables and lane-replicated write data, and returns load data aligned to bit 0 with zero or sign extension. Flags misaligned, reserved-size and bus-timeout errors to the exception logic. One access in flight; no queueing.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_access_ctrl_if.sv | 42 ++++
 rtl/mem_access_ctrl_load_extract.sv | 26 ++
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, error causes,
// FSM states, and the lane helpers used by the controller.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_MISALIGN  = 2'b01,
        CAUSE_TIMEOUT   = 2'b10,
        CAUSE_RSVD_SIZE = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    // Half ignores addr[0] and word ignores addr[1:0]; alignment is trapped elsewhere.
    function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input size_e size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and data-memory bus signals of the sequencer.
// slave: the controller; master: the CPU stage plus the memory it talks to.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_cause;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_cause,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_cause,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_load_extract.sv
// Load-data lane select with zero/sign extension to a right-justified 32-bit word.
module load_extract
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_sext,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
            SZ_WORD: o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer between the CPU memory stage and the data bus.
// Optional feature: define MEM_ALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              clrn,
    mem_access_ctrl_if.slave bus
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e        r_state;
    state_e        w_state_nxt;

    logic          r_we;
    logic          r_sext;
    size_e         r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    cause_e        r_cause;
    logic [CW-1:0] r_cnt;

    size_e         w_req_size;
    logic          w_misalign;
    logic          w_req_err;
    logic          w_timeout;
    logic [31:0]   w_ext;

    assign w_req_size = size_e'(bus.req_size);

`ifdef MEM_ALIGN_TRAP_EN
    assign w_misalign = misaligned(w_req_size, bus.req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = (w_req_size == SZ_RSVD) || w_misalign;

    // Fires on the BUS cycle whose missing ack would bring the wait count to TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT);

    load_extract u_load_extract (
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_sext    (r_sext),
        .i_rdata   (bus.mem_rdata),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_req_err ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.mem_ack || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cause <= CAUSE_NONE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_sext  <= bus.req_sext;
                        r_size  <= w_req_size;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_rdata <= '0;
                        r_cnt   <= '0;
                        r_err   <= w_req_err;
                        if (w_req_size == SZ_RSVD) begin
                            r_cause <= CAUSE_RSVD_SIZE;
                        end else if (w_misalign) begin
                            r_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_cause <= CAUSE_NONE;
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the timeout cycle takes priority and completes normally.
                    if (bus.mem_ack) begin
                        r_rdata <= r_we ? '0 : w_ext;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_cause <= CAUSE_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.rsp_cause = CAUSE_NONE;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_BUS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_be    = byte_enables(r_size, r_addr[1:0]);
                bus.mem_addr  = {r_addr[31:2], 2'b00};
                bus.mem_wdata = lane_replicate(r_size, r_wdata);
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = r_rdata;
                bus.rsp_err   = r_err;
                bus.rsp_cause = r_cause;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues accesses and queues the
// expected bus transfer and response; a memory responder and a response monitor check them.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int unsigned TO = 15;
    localparam int NEVER = 1000;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   cyc  = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        abort;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: an access touches n = 2^size consecutive bytes, starting at the
    // offset within the word rounded down to a multiple of n.
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic int lane_off(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = nbytes(size);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = nbytes(size);
        return 4'(((1 << n) - 1) << lane_off(size, addr));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        int n;
        n = nbytes(size);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sext,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [63:0] v;
        logic [63:0] mask;
        int n;
        n    = nbytes(size);
        v    = {32'd0, rdata} >> (8 * lane_off(size, addr));
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (sext && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] rdata, input logic abort);
        int   n_acc;
        int   guard;
        logic mis;
        bus_t b;
        rsp_t r;
`ifdef MEM_ALIGN_TRAP_EN
        mis = (size != 2'b11) && ((addr % nbytes(size)) != 0);
`else
        mis = 1'b0;
`endif
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                flag("req_ready_wait_expired");
                bus.req_valid = 1'b0;
                return;
            end
        end
        n_acc = cyc + 1;
        if (size == 2'b11) begin
            r = '{32'd0, 1'b1, 2'b11, n_acc};
            rsp_q.push_back(r);
        end else if (mis) begin
            r = '{32'd0, 1'b1, 2'b01, n_acc};
            rsp_q.push_back(r);
        end else begin
            b = '{addr & 32'hFFFF_FFFC, model_be(size, addr), we, model_wdata(size, wdata),
                  delay, rdata, abort};
            bus_q.push_back(b);
            if (!abort) begin
                if (delay >= int'(TO)) r = '{32'd0, 1'b1, 2'b10, n_acc + int'(TO)};
                else r = '{we ? 32'd0 : model_load(size, sext, addr, rdata), 1'b0, 2'b00,
                           n_acc + delay + 1};
                rsp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_sext  = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Memory responder: checks each bus transfer against the queued expectation and
    // acks after the planned number of wait cycles; random stray acks while idle.
    initial begin
        bus_t cur;
        bit   active;
        int   seen;
        active = 1'b0;
        seen   = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        flag("unexpected_mem_req");
                    end else begin
                        cur    = bus_q.pop_front();
                        active = 1'b1;
                        seen   = 0;
                    end
                end
                if (active) begin
                    check("mem_addr", bus.mem_addr, cur.addr);
                    check("mem_be", 32'(bus.mem_be), 32'(cur.be));
                    check("mem_we", 32'(bus.mem_we), 32'(cur.we));
                    if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                    if (seen == cur.delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = cur.rdata;
                    end
                    seen++;
                end
            end else begin
                if (active) begin
                    if (!cur.abort) begin
                        if (cur.delay >= int'(TO)) check("timeout_req_cycles", 32'(seen), TO);
                        else check("ack_req_cycles", 32'(seen), 32'(cur.delay + 1));
                    end
                    active = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) bus.mem_ack = 1'b1;
            end
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (clrn && bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    flag("unexpected_rsp_valid");
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    check("rsp_cause", 32'(bus.rsp_cause), 32'(e.cause));
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int guard;
        logic [1:0] sz;
        int d;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        clrn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_rsp_cause", 32'(bus.rsp_cause), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check("reset_mem_we", 32'(bus.mem_we), 32'd0);
        check("reset_mem_be", 32'(bus.mem_be), 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);
        check("reset_mem_wdata", bus.mem_wdata, 32'd0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80F0_F0F0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 2, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, NEVER, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_005A, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 0, 32'hF0F0_0000, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 3, 32'h8001_7FFF, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0, int'(TO) - 1, 32'h0099_0000, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFE_F00D, int'(TO) - 2, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       d = NEVER;
                1:       d = int'(TO) - 1;
                default: d = $urandom_range(0, 4);
            endcase
            issue(1'($urandom), sz, 1'($urandom), $urandom, $urandom, d, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, NEVER, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        check("bus_before_reset_mem_req", 32'(bus.mem_req), 32'd1);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check("abort_mem_req", 32'(bus.mem_req), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (20) @(negedge clk);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0601, 32'h0, 1, 32'h1234_5678, 1'b0);

        guard = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_q.size() != 0 || bus_q.size() != 0) flag("pending_expectations_at_end");
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
